// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared definitions for the iterative RV64M divider.
//   - funct3 codes for DIV/DIVU/REM/REMU
//   - 2-bit FSM state encoding
//   - XLEN and per-width constants
//   - div_result(): sign correction, special-case override, W sign-extension
// Build option: define DIV_EARLY_OUT_EN to resolve b==0 and signed overflow
// at accept time (IDLE->DONE) instead of running the full iteration count.
package div_unit_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  // Most-negative values after operand extension (W values are sign-extended).
  localparam logic [XLEN-1:0] MIN_D = 64'h8000_0000_0000_0000;
  localparam logic [XLEN-1:0] MIN_W = 64'hFFFF_FFFF_8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Turns unsigned quotient/remainder magnitudes into the architectural result.
  // a_ext is the dividend after width truncation/extension; it is the answer
  // for REM by zero and for the overflowing quotient.
  function automatic logic [XLEN-1:0] div_result(
    input logic [XLEN-1:0] q,
    input logic [XLEN-1:0] r,
    input logic [XLEN-1:0] a_ext,
    input logic            q_neg,
    input logic            r_neg,
    input logic            sel_rem,
    input logic            word,
    input logic            b_zero,
    input logic            ovf
  );
    logic [XLEN-1:0] qs, rs, res;
    qs = q_neg ? -q : q;
    rs = r_neg ? -r : r;
    if (b_zero) begin
      qs = '1;
      rs = a_ext;
    end else if (ovf) begin
      qs = a_ext;
      rs = '0;
    end
    res = sel_rem ? rs : qs;
    if (word) res = {{32{res[31]}}, res[31:0]};
    return res;
  endfunction

endpackage

// File: rtl/div_core.sv
// div_core: one restoring radix-2 step, purely combinational.
//   rem, quo  : current partial remainder / quotient-dividend shift register
//   dvsr      : divisor magnitude
//   next_rem, next_quo : state after shift-left and trial subtract
module div_core
  import div_unit_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN-1:0] next_rem,
  output logic [XLEN-1:0] next_quo
);

  // The shifted remainder can reach 65 bits for full-width divides.
  logic [XLEN:0] shifted;
  logic          borrow;

  assign shifted  = {rem, quo[XLEN-1]};
  assign borrow   = shifted < {1'b0, dvsr};
  // On no-borrow the difference is below dvsr, so the low 64 bits are exact.
  assign next_rem = borrow ? shifted[XLEN-1:0] : shifted[XLEN-1:0] - dvsr;
  assign next_quo = {quo[XLEN-2:0], ~borrow};

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 divider sequencer for the RV64M EX stage.
// Executes DIV/DIVU/REM/REMU and W variants; drives the EX divide stall.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   start_i          : EX holds a divide/remainder op
//   funct3_i, word_i : op select (1xx valid), W variant
//   a_i, b_i         : dividend, divisor
//   kill_i           : abort in-flight op
//   busy_o           : stall request (combinational from start_i in IDLE)
//   done_o, result_o : one-cycle completion pulse, registered result
// Build option: DIV_EARLY_OUT_EN - b==0 / signed overflow finish in one cycle.
module div_unit
  import div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  state_t state, next_state;

  logic [XLEN-1:0] rem_r, quo_r, dvsr_r, a_ext_r, result_r;
  logic [5:0]      cnt;
  logic            q_neg_r, r_neg_r, sel_rem_r, word_r, b_zero_r, ovf_r;
  logic [XLEN-1:0] next_rem, next_quo;

  // ---------------- operand decode (accept cycle) ----------------
  logic            is_valid, is_signed, accept;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
  logic            a_neg, b_neg, b_zero_in, ovf_in;

  assign is_valid  = funct3_i inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
  assign is_signed = (funct3_i == F3_DIV) || (funct3_i == F3_REM);
  assign accept    = (state == S_IDLE) && start_i && is_valid && !kill_i;

  assign a_ext = !word_i   ? a_i :
                 is_signed ? {{32{a_i[31]}}, a_i[31:0]} : {32'b0, a_i[31:0]};
  assign b_ext = !word_i   ? b_i :
                 is_signed ? {{32{b_i[31]}}, b_i[31:0]} : {32'b0, b_i[31:0]};
  assign a_neg = is_signed && a_ext[XLEN-1];
  assign b_neg = is_signed && b_ext[XLEN-1];
  assign a_mag = a_neg ? -a_ext : a_ext;
  assign b_mag = b_neg ? -b_ext : b_ext;

  assign b_zero_in = (b_ext == '0);
  assign ovf_in    = is_signed && (a_ext == (word_i ? MIN_W : MIN_D)) && (b_ext == '1);

  div_core u_core (
    .rem      (rem_r),
    .quo      (quo_r),
    .dvsr     (dvsr_r),
    .next_rem (next_rem),
    .next_quo (next_quo)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE: begin
        next_state = S_IDLE;
        if (accept) begin
`ifdef DIV_EARLY_OUT_EN
          next_state = (b_zero_in || ovf_in) ? S_DONE : S_BUSY;
`else
          next_state = S_BUSY;
`endif
        end
      end
      S_BUSY: begin
        if (kill_i)        next_state = S_IDLE;
        else if (cnt == 0) next_state = S_DONE;
        else               next_state = S_BUSY;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = accept || (state == S_BUSY);
    done_o = (state == S_DONE);
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_r     <= '0;
      quo_r     <= '0;
      dvsr_r    <= '0;
      a_ext_r   <= '0;
      result_r  <= '0;
      cnt       <= '0;
      q_neg_r   <= 1'b0;
      r_neg_r   <= 1'b0;
      sel_rem_r <= 1'b0;
      word_r    <= 1'b0;
      b_zero_r  <= 1'b0;
      ovf_r     <= 1'b0;
    end else if (accept) begin
      rem_r     <= '0;
      // W dividends sit in the upper half so 32 shifts drain them fully.
      quo_r     <= word_i ? {a_mag[31:0], 32'b0} : a_mag;
      dvsr_r    <= b_mag;
      a_ext_r   <= a_ext;
      cnt       <= word_i ? 6'd31 : 6'd63;
      q_neg_r   <= a_neg ^ b_neg;
      r_neg_r   <= a_neg;
      sel_rem_r <= funct3_i[1];
      word_r    <= word_i;
      b_zero_r  <= b_zero_in;
      ovf_r     <= ovf_in;
`ifdef DIV_EARLY_OUT_EN
      if (b_zero_in || ovf_in)
        result_r <= div_result('0, '0, a_ext, a_neg ^ b_neg, a_neg,
                               funct3_i[1], word_i, b_zero_in, ovf_in);
`endif
    end else if (state == S_BUSY && !kill_i) begin
      rem_r <= next_rem;
      quo_r <= next_quo;
      if (cnt != 0) begin
        cnt <= cnt - 6'd1;
      end else begin
        result_r <= div_result(next_quo, next_rem, a_ext_r, q_neg_r, r_neg_r,
                               sel_rem_r, word_r, b_zero_r, ovf_r);
      end
    end
  end

  assign result_o = result_r;

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 divider sequencer for the RV64M EX stage. It executes DIV/DIVU/REM/REMU and the W variants over multiple cycles. While it is busy, it drives the EX-stage divide stall request, so IF, IF/ID and ID/EX hold and EX/MEM is flushed. It owns the operand/remainder registers, the iteration counter, the sign correction and the RISC-V special-case results.

## Interface
- No parameters. Data width is fixed at 64; word ops use 32.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start_i` in 1: EX holds a valid M-extension divide/remainder op.
- `funct3_i` in 3: 100 DIV, 101 DIVU, 110 REM, 111 REMU. Other values are ignored (no start).
- `word_i` in 1: selects the W variant (DIVW, DIVUW, REMW, REMUW).
- `a_i` in 64: dividend.
- `b_i` in 64: divisor.
- `kill_i` in 1: abort any in-flight operation.
- `busy_o` out 1: stall request to pipeline control (the divide stall input).
- `done_o` out 1: one-cycle pulse; `result_o` is valid in this cycle.
- `result_o` out 64: quotient or remainder, sign-extended for W ops.

## Operation
- FSM states:
  - IDLE → BUSY on a valid `start_i` (DONE instead if early-out applies, see Configuration).
  - BUSY → DONE when the counter reaches 0.
  - DONE → IDLE unconditionally.
  - Any state → IDLE on `kill_i`.
- Operand latch at start:
  - W ops truncate to [31:0]. Signed ops sign-extend; unsigned ops zero-extend.
  - Signed ops take magnitudes and record the quotient sign (a xor b) and the remainder sign (a).
- Iteration, once per BUSY cycle, restoring:
  - Shift {rem, quo} left by 1, then trial-subtract the divisor from rem.
  - If the subtraction does not borrow, keep the difference and set quo[0]=1.
  - Counter loads N-1, where N=64 (N=32 for W), and decrements each cycle.
- Final correction, registered into `result_o` on entry to DONE:
  - Negate the quotient/remainder per the recorded signs.
  - Select the quotient or remainder per funct3[1].
  - W ops sign-extend bit 31 to 64, including DIVUW and REMUW.
- Special cases override the final result regardless of macro:
  - b==0: quotient = all ones (per width); remainder = a (per width, sign-extended for W).
  - Signed overflow, a==most-negative and b==-1 (per width): quotient = a; remainder = 0.
- `busy_o` = (IDLE & `start_i` & valid funct3 & ~`kill_i`) | BUSY. It is combinational from `start_i` so that the stall takes effect in the accept cycle.
- In DONE, `busy_o`=0. The pipeline advances and EX/MEM captures `result_o`. `start_i` in DONE is ignored, because it belongs to the same instruction.
- `result_o` holds its value until the next DONE entry.

## Timing
- Accept at cycle T: operands are latched and state=BUSY at T+1.
- BUSY occupies T+1..T+N. DONE (`done_o`=1) is at T+N+1.
- Latency:
  - 65 cycles for 64-bit ops; 33 for W ops.
  - `busy_o` is high T..T+N, i.e. 65 or 33 cycles.
- Back-to-back: IDLE at T+N+2 can accept the next start the same cycle.
- `kill_i` with `start_i` in IDLE: not accepted.
- `kill_i` in BUSY: IDLE next cycle, no `done_o`, `result_o` unchanged.
- `kill_i` in DONE: `done_o` still pulses this cycle, then IDLE.
- Reset (any time, asynchronous):
  - state=IDLE, counter=0, `done_o`=0, `result_o`=0, internal registers 0.
  - `busy_o` is then 0 unless `start_i` is asserted.

## Configuration
- `DIV_EARLY_OUT_EN` defined: b==0 and signed overflow are detected at accept. The FSM goes IDLE→DONE directly, so `busy_o` is high for cycle T only and `done_o` is high at T+1.
- Not defined: special cases run the full N iterations, with the same results and the full 65/33-cycle latency.

## Structure
- Shared define header holds:
  - funct3 codes DIV/DIVU/REM/REMU.
  - FSM state encodings (2-bit).
  - XLEN=64.
  - The `DIV_EARLY_OUT_EN` switch.
- One sub-module, `div_core`: the shift/trial-subtract step, purely combinational. Inputs are rem, quo and divisor; outputs are next_rem and next_quo.
- `div_unit` holds the FSM, counter, registers, sign correction and special-case mux.

## Test plan
- DIVU a=100, b=7: `busy_o` high 65 cycles, `done_o` at T+65, `result_o`=14. REMU with the same operands gives 2.
- DIV a=-7, b=2: result=-3 (0xFFFF_FFFF_FFFF_FFFD). REM with the same operands gives -1.
- DIVW a=0x0000_0001_8000_0000, b=-1: overflow, result=0xFFFF_FFFF_8000_0000. REMW gives 0. With the macro, `done_o` at T+1; without it, at T+33.
- DIVU b=0, a=5: result=0xFFFF_FFFF_FFFF_FFFF. REMU b=0 gives 5. REMUW with a=0x8000_0000, b=0 gives 0xFFFF_FFFF_8000_0000.
- `kill_i` at T+10 of a 64-bit DIV: IDLE at T+11, no `done_o`, `result_o` holds its prior value. A new start at T+11 completes normally.
- `rst` pulsed mid-BUSY, asynchronously between edges: `done_o`=0 and `result_o`=0 immediately, `busy_o`=0. A subsequent op completes correctly.
